// File: rtl/demux_scheduler.sv
// demux_scheduler: round-robin sequencer that feeds 4-bit symbols of one
// frame into NUM_LANES demux lanes through a one-slot hold register.
// Lane order is strict; a stalled lane holds up the whole frame.

// One lane's strobe: high while the held symbol is addressed to this lane.
module demux_lane_strobe #(
   parameter int SEL_W = 3,
   parameter int LANE  = 0
) (
   input  logic             inHoldValid,
   input  logic [SEL_W-1:0] inSel,
   output logic             outStrobe
);
   assign outStrobe = inHoldValid && (inSel == SEL_W'(LANE));
endmodule

module demux_scheduler #(
   parameter int NUM_LANES = 8,
   parameter int SEL_W     = 3,
   parameter int DATA_W    = 4,
   parameter int LEN_W     = 8
) (
   input  logic                 inClk,
   input  logic                 inRstN,
   input  logic                 inStart,
   input  logic [LEN_W-1:0]     inLen,
   input  logic [DATA_W-1:0]    inData,
   input  logic                 inValid,
   output logic                 outReady,
   input  logic [NUM_LANES-1:0] inLaneReady,
   output logic [SEL_W-1:0]     outSel,
   output logic [DATA_W-1:0]    outData,
   output logic [NUM_LANES-1:0] outLaneValid,
   output logic                 outBusy,
   output logic                 outDone
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

   localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(NUM_LANES - 1);

   stateT                 stateQ, stateD;
   logic                  holdValid;
   logic [SEL_W-1:0]      ptr;
   logic [LEN_W-1:0]      rem;
   logic [2**SEL_W-1:0]   laneReadyPad;
   logic                  drain;
   logic                  accept;

   // Widen per-lane ready to the full select range so outSel always indexes a real bit
   always_comb begin
      laneReadyPad                  = '0;
      laneReadyPad[NUM_LANES-1:0]   = inLaneReady;
   end

   assign drain  = holdValid && laneReadyPad[outSel];
   assign accept = inValid && outReady;

   // FSM state register
   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) stateQ <= IDLE;
      else         stateQ <= stateD;
   end

   // FSM next state: a frame ends once nothing is left to accept and the slot empties
   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE:    if (inStart) stateD = (inLen != '0) ? RUN : DONE;
         RUN:     if (rem == '0 && (!holdValid || drain)) stateD = DONE;
         DONE:    stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   // FSM outputs: accept whenever the slot is free or is being emptied this cycle
   always_comb begin
      outBusy  = (stateQ == RUN);
      outDone  = (stateQ == DONE);
      outReady = (stateQ == RUN) && (rem != '0) && (!holdValid || drain);
   end

   // Hold slot, lane pointer and remaining count; refill on drain gives no bubble
   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         holdValid <= 1'b0;
         outData   <= '0;
         outSel    <= '0;
         ptr       <= '0;
         rem       <= '0;
      end else begin
         if (stateQ == IDLE && inStart) begin
            ptr <= '0;
            rem <= inLen;
         end
         if (accept) begin
            outData   <= inData;
            outSel    <= ptr;
            holdValid <= 1'b1;
            ptr       <= (ptr == LAST_LANE) ? '0 : ptr + 1'b1;
            rem       <= rem - 1'b1;
         end else if (drain) begin
            holdValid <= 1'b0;
         end
      end
   end

   // One strobe instance per lane
   for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
      demux_lane_strobe #(.SEL_W(SEL_W), .LANE(i)) uStrobe (
         .inHoldValid(holdValid),
         .inSel      (outSel),
         .outStrobe  (outLaneValid[i])
      );
   end

endmodule

// File: tb/tb_demux_scheduler.sv
// Bench for demux_scheduler: an 8-lane and a 5-lane instance, a per-cycle
// vector table for the full-rate frame, hand sequences for stall, zero
// length, ignored start and mid-frame reset, plus a drain scoreboard.
module tb_demux_scheduler;

   logic       inClk = 1'b0;
   logic       rstN;
   logic       inStart, inStart5;
   logic [7:0] inLen;
   logic [3:0] inData;
   logic       inValid;
   logic [7:0] inLaneReady;
   logic [4:0] inLaneReady5;

   logic       outReady,  o5Ready;
   logic [2:0] outSel,    o5Sel;
   logic [3:0] outData,   o5Data;
   logic [7:0] outLaneValid;
   logic [4:0] o5LaneValid;
   logic       outBusy,   o5Busy;
   logic       outDone,   o5Done;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [2:0] sel;
      logic [3:0] data;
   } expT;

   expT q8[$];
   expT q5[$];
   int  ptr8 = 0;
   int  ptr5 = 0;

   always #5 inClk = ~inClk;

   demux_scheduler #(.NUM_LANES(8), .SEL_W(3), .DATA_W(4), .LEN_W(8)) dut8 (
      .inClk(inClk), .inRstN(rstN), .inStart(inStart), .inLen(inLen),
      .inData(inData), .inValid(inValid), .outReady(outReady),
      .inLaneReady(inLaneReady), .outSel(outSel), .outData(outData),
      .outLaneValid(outLaneValid), .outBusy(outBusy), .outDone(outDone)
   );

   demux_scheduler #(.NUM_LANES(5), .SEL_W(3), .DATA_W(4), .LEN_W(8)) dut5 (
      .inClk(inClk), .inRstN(rstN), .inStart(inStart5), .inLen(inLen),
      .inData(inData), .inValid(inValid), .outReady(o5Ready),
      .inLaneReady(inLaneReady5), .outSel(o5Sel), .outData(o5Data),
      .outLaneValid(o5LaneValid), .outBusy(o5Busy), .outDone(o5Done)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic failNow(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: drain seen with empty scoreboard (t=%0t)", nm, $time);
   endtask

   // Drive one cycle's inputs at the falling edge; returns 1 time unit later
   task automatic applyCycle(input logic st, input logic [7:0] len, input logic vld,
                             input logic [3:0] d, input logic [7:0] lr,
                             input logic st5, input logic [4:0] lr5);
      @(negedge inClk);
      inStart      = st;
      inLen        = len;
      inValid      = vld;
      inData       = d;
      inLaneReady  = lr;
      inStart5     = st5;
      inLaneReady5 = lr5;
      #1;
   endtask

   // Scoreboard: push on accept, pop and compare on lane drain
   always @(negedge inClk) begin
      int idx;
      expT e;
      #2;
      if (!rstN) begin
         ptr8 = 0;
         ptr5 = 0;
      end else begin
         if (inStart && !outBusy && !outDone) ptr8 = 0;
         if (inStart5 && !o5Busy && !o5Done) ptr5 = 0;
         idx = int'(outSel);
         if (outLaneValid != 8'h0 && inLaneReady[idx]) begin
            if (q8.size() == 0) failNow("sb8");
            else begin
               e = q8.pop_front();
               chk("sb8 sel", 32'(outSel), 32'(e.sel));
               chk("sb8 data", 32'(outData), 32'(e.data));
               chk("sb8 strobe", 32'(outLaneValid), 32'(8'h1 << e.sel));
            end
         end
         if (inValid && outReady) begin
            q8.push_back('{sel: 3'(ptr8), data: inData});
            ptr8 = (ptr8 + 1) % 8;
         end
         idx = int'(o5Sel);
         if (o5LaneValid != 5'h0 && idx < 5 && inLaneReady5[idx]) begin
            if (q5.size() == 0) failNow("sb5");
            else begin
               e = q5.pop_front();
               chk("sb5 sel", 32'(o5Sel), 32'(e.sel));
               chk("sb5 data", 32'(o5Data), 32'(e.data));
               chk("sb5 strobe", 32'(o5LaneValid), 32'(5'h1 << e.sel));
            end
         end
         if (inValid && o5Ready) begin
            q5.push_back('{sel: 3'(ptr5), data: inData});
            ptr5 = (ptr5 + 1) % 5;
         end
      end
   end

   typedef struct {
      logic       st;
      logic [7:0] len;
      logic       vld;
      logic [3:0] d;
      logic       expReady;
      logic       expBusy;
      logic       expDone;
      logic [7:0] expLv;
   } vecT;

   function automatic vecT mk(input logic st, input logic [7:0] len, input logic vld,
                              input logic [3:0] d, input logic er, input logic eb,
                              input logic ed, input logic [7:0] elv);
      vecT v;
      v.st = st; v.len = len; v.vld = vld; v.d = d;
      v.expReady = er; v.expBusy = eb; v.expDone = ed; v.expLv = elv;
      return v;
   endfunction

   initial begin
      vecT        vec[14];
      logic [2:0] expSel5[7];

      // Full-rate frame, length 10, every lane ready
      vec[0]  = mk(1, 10, 0, 4'h0, 0, 0, 0, 8'h00);
      vec[1]  = mk(0, 0,  1, 4'h1, 1, 1, 0, 8'h00);
      vec[2]  = mk(0, 0,  1, 4'h2, 1, 1, 0, 8'h01);
      vec[3]  = mk(0, 0,  1, 4'h3, 1, 1, 0, 8'h02);
      vec[4]  = mk(0, 0,  1, 4'h4, 1, 1, 0, 8'h04);
      vec[5]  = mk(0, 0,  1, 4'h5, 1, 1, 0, 8'h08);
      vec[6]  = mk(0, 0,  1, 4'h6, 1, 1, 0, 8'h10);
      vec[7]  = mk(0, 0,  1, 4'h7, 1, 1, 0, 8'h20);
      vec[8]  = mk(0, 0,  1, 4'h8, 1, 1, 0, 8'h40);
      vec[9]  = mk(0, 0,  1, 4'h9, 1, 1, 0, 8'h80);
      vec[10] = mk(0, 0,  1, 4'hA, 1, 1, 0, 8'h01);
      vec[11] = mk(0, 0,  0, 4'h0, 0, 1, 0, 8'h02);
      vec[12] = mk(0, 0,  0, 4'h0, 0, 0, 1, 8'h00);
      vec[13] = mk(0, 0,  0, 4'h0, 0, 0, 0, 8'h00);
      expSel5 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};

      inStart = 0; inStart5 = 0; inLen = 0; inValid = 0; inData = 0;
      inLaneReady = 8'hFF; inLaneReady5 = 5'h1F;

      // Reset state
      rstN = 1'b1;
      #2 rstN = 1'b0;
      #1;
      chk("rst ready", 32'(outReady), 0);
      chk("rst sel", 32'(outSel), 0);
      chk("rst data", 32'(outData), 0);
      chk("rst lanevalid", 32'(outLaneValid), 0);
      chk("rst busy", 32'(outBusy), 0);
      chk("rst done", 32'(outDone), 0);
      chk("rst5 lanevalid", 32'(o5LaneValid), 0);
      repeat (2) @(posedge inClk);
      @(negedge inClk);
      rstN = 1'b1;

      // Full-rate table
      for (int i = 0; i < 14; i++) begin
         applyCycle(vec[i].st, vec[i].len, vec[i].vld, vec[i].d, 8'hFF, 0, 5'h1F);
         chk($sformatf("full c%0d ready", i), 32'(outReady), 32'(vec[i].expReady));
         chk($sformatf("full c%0d busy", i), 32'(outBusy), 32'(vec[i].expBusy));
         chk($sformatf("full c%0d done", i), 32'(outDone), 32'(vec[i].expDone));
         chk($sformatf("full c%0d lanevalid", i), 32'(outLaneValid), 32'(vec[i].expLv));
      end

      // Lane stall: lane 1 not ready for 5 cycles
      applyCycle(1, 3, 0, 4'h0, 8'hFF, 0, 5'h1F);
      applyCycle(0, 0, 1, 4'h1, 8'hFF, 0, 5'h1F);
      applyCycle(0, 0, 1, 4'h2, 8'hFF, 0, 5'h1F);
      for (int c = 0; c < 5; c++) begin
         applyCycle(0, 0, 1, 4'h3, 8'hFD, 0, 5'h1F);
         chk("stall ready", 32'(outReady), 0);
         chk("stall sel", 32'(outSel), 1);
         chk("stall data", 32'(outData), 2);
         chk("stall lanevalid", 32'(outLaneValid), 32'h02);
      end
      applyCycle(0, 0, 1, 4'h3, 8'hFF, 0, 5'h1F);
      chk("stall release ready", 32'(outReady), 1);
      applyCycle(0, 0, 0, 4'h0, 8'hFF, 0, 5'h1F);
      chk("stall sym3 lanevalid", 32'(outLaneValid), 32'h04);
      chk("stall sym3 data", 32'(outData), 3);
      applyCycle(0, 0, 0, 4'h0, 8'hFF, 0, 5'h1F);
      chk("stall done", 32'(outDone), 1);

      // Zero length frame
      applyCycle(0, 0, 0, 4'h0, 8'hFF, 0, 5'h1F);
      applyCycle(1, 0, 1, 4'h7, 8'hFF, 0, 5'h1F);
      chk("zero c0 busy", 32'(outBusy), 0);
      chk("zero c0 ready", 32'(outReady), 0);
      applyCycle(0, 0, 1, 4'h7, 8'hFF, 0, 5'h1F);
      chk("zero c1 done", 32'(outDone), 1);
      chk("zero c1 busy", 32'(outBusy), 0);
      applyCycle(0, 0, 0, 4'h0, 8'hFF, 0, 5'h1F);
      chk("zero c2 done", 32'(outDone), 0);
      chk("zero c2 busy", 32'(outBusy), 0);

      // Ignored start in RUN and in DONE; inValid ignored outside RUN
      for (int c = 0; c < 14; c++) begin
         applyCycle(c == 0 || c == 4 || c == 11, (c == 0) ? 8'd9 : ((c == 4) ? 8'd3 : 8'd5),
                    c >= 1, 4'(c), 8'hFF, 0, 5'h1F);
         chk($sformatf("ign c%0d ready", c), 32'(outReady), 32'(c >= 1 && c <= 9));
         chk($sformatf("ign c%0d busy", c), 32'(outBusy), 32'(c >= 1 && c <= 10));
         chk($sformatf("ign c%0d done", c), 32'(outDone), 32'(c == 11));
      end
      applyCycle(0, 0, 0, 4'h0, 8'hFF, 0, 5'h1F);

      // Non-power-of-2 lane count on the 5-lane instance
      for (int c = 0; c < 11; c++) begin
         applyCycle(0, (c == 0) ? 8'd7 : 8'd0, c >= 1 && c <= 7, 4'(c), 8'hFF, c == 0, 5'h1F);
         if (c >= 2 && c <= 8) begin
            chk($sformatf("np2 c%0d sel", c), 32'(o5Sel), 32'(expSel5[c-2]));
            chk($sformatf("np2 c%0d lanevalid", c), 32'(o5LaneValid), 32'(5'h1 << expSel5[c-2]));
         end
         chk($sformatf("np2 c%0d done", c), 32'(o5Done), 32'(c == 9));
      end

      // Reset asserted mid-frame while lane 1 is stalled
      applyCycle(1, 10, 0, 4'h0, 8'hFF, 0, 5'h1F);
      applyCycle(0, 0, 1, 4'h1, 8'hFF, 0, 5'h1F);
      applyCycle(0, 0, 1, 4'h2, 8'hFF, 0, 5'h1F);
      applyCycle(0, 0, 1, 4'h3, 8'hFD, 0, 5'h1F);
      chk("midrst pre lanevalid", 32'(outLaneValid), 32'h02);
      #2 rstN = 1'b0;
      #1;
      chk("midrst ready", 32'(outReady), 0);
      chk("midrst sel", 32'(outSel), 0);
      chk("midrst data", 32'(outData), 0);
      chk("midrst lanevalid", 32'(outLaneValid), 0);
      chk("midrst busy", 32'(outBusy), 0);
      chk("midrst done", 32'(outDone), 0);
      q8.delete();
      @(negedge inClk);
      rstN = 1'b1;
      for (int c = 0; c < 4; c++) begin
         applyCycle(0, 0, 1, 4'h5, 8'hFF, 0, 5'h1F);
         chk("postrst busy", 32'(outBusy), 0);
         chk("postrst done", 32'(outDone), 0);
         chk("postrst ready", 32'(outReady), 0);
      end

      applyCycle(0, 0, 0, 4'h0, 8'hFF, 0, 5'h1F);
      chk("sb8 leftover", 32'(q8.size()), 0);
      chk("sb5 leftover", 32'(q5.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/demux_scheduler.md
# demux_scheduler

Sequencer for the symbol demultiplexer of the Zigbee datapath. Accepts a frame of 4-bit symbols over a valid/ready handshake, assigns them in strict round-robin order to NUM_LANES output lanes, and drives the demux select, data and one-hot lane strobe. Each lane has its own ready for backpressure. Sits between the symbol source and the DEMUX bank, and reports busy/done to the frame controller.

## Interface
Parameters:
- NUM_LANES, 8: number of output lanes (2..2^SEL_W).
- SEL_W, 3: select width; must satisfy 2^SEL_W >= NUM_LANES.
- DATA_W, 4: symbol width.
- LEN_W, 8: frame-length counter width.

Ports:
- inClk  in  1  clock; all logic is on the rising edge.
- inRstN  in  1  asynchronous active-low reset.
- inStart  in  1  single-cycle frame start pulse; sampled only in IDLE.
- inLen  in  LEN_W  frame length in symbols; sampled with inStart.
- inData  in  DATA_W  input symbol.
- inValid  in  1  inData is valid.
- outReady  out  1  scheduler accepts inData this cycle.
- inLaneReady  in  NUM_LANES  per-lane ready.
- outSel  out  SEL_W  demux select (lane index of the held symbol).
- outData  out  DATA_W  held symbol.
- outLaneValid  out  NUM_LANES  one-hot strobe of the held lane; zero when no symbol is held.
- outBusy  out  1  high in RUN.
- outDone  out  1  single-cycle pulse at frame end.

## Operation
- State is a one-slot hold register (holdValid, outData, outSel), a lane pointer ptr, a remaining counter rem, and an FSM with states IDLE, RUN and DONE.
- IDLE:
  - inStart && inLen != 0 -> RUN; rem = inLen, ptr = 0.
  - inStart && inLen == 0 -> DONE. No symbols are transferred.
- RUN:
  - Drain: a lane transfer occurs when holdValid && inLaneReady[outSel]. It clears holdValid unless a refill happens in the same cycle.
  - outReady = (rem != 0) && (!holdValid || drain). This is combinational from state and inLaneReady.
  - Accept: on inValid && outReady:
    - outData = inData.
    - outSel = ptr.
    - holdValid = 1.
    - ptr = (ptr == NUM_LANES-1) ? 0 : ptr+1.
    - rem = rem-1.
  - Drain and accept in the same cycle: the slot is replaced; there is no bubble.
  - rem == 0 && !holdValid -> DONE. A final drain cycle with rem == 0 also goes to DONE on the same edge.
- DONE: outDone = 1 for exactly one cycle, then -> IDLE.
- inStart in RUN or DONE is ignored. inLen is not retained beyond the start cycle.
- inValid while not in RUN is ignored (outReady = 0).
- Lane order is strict. A stalled lane blocks all further traffic; no lane is skipped.
- ptr resets to 0 at every frame start, so each frame begins on lane 0.
- Arithmetic: ptr wraps at NUM_LANES-1, not at 2^SEL_W. rem is an unsigned down-counter and never decrements below 0.

## Timing
- Reset (inRstN low, asynchronous):
  - State = IDLE.
  - outReady = 0, outSel = 0, outData = 0, outLaneValid = 0.
  - outBusy = 0, outDone = 0.
  - ptr = 0, rem = 0, holdValid = 0.
- Reset asserted mid-frame aborts immediately. No outDone is produced.
- Start latency: inStart at edge k -> outBusy high and outReady eligible from cycle k+1.
- Symbol latency: accepted at edge k -> on outData/outSel/outLaneValid from edge k until the edge where it drains.
- Throughput: 1 symbol/cycle while the addressed lanes are ready.
- Frame end:
  - Last symbol drains at edge d -> outDone high in cycle d+1, IDLE at d+2.
  - inStart is first honoured in cycle d+2.
- inLen == 0: inStart at edge k -> outDone in cycle k+1.
- outBusy = (state == RUN).
- outLaneValid = holdValid ? (1 << outSel) : 0.

## Test plan
- Reset: drive inRstN low mid-frame -> all outputs 0 asynchronously, IDLE after release, no outDone.
- Full-rate frame: inLen=10, symbols 0x1..0xA with inValid and all lanes ready continuously:
  - outSel sequence is 0,1,...,7,0,1.
  - outLaneValid is 0x01..0x80,0x01,0x02.
  - One symbol per cycle; outDone one cycle after the last drain.
- Lane stall: inLen=3, inLaneReady[1]=0 for 5 cycles:
  - Symbol 2 holds on outSel=1 for 5 cycles.
  - outReady=0 during the stall.
  - Lane 2 receives symbol 3 only after the stall; no skip.
- Zero length: inStart with inLen=0 -> outDone pulse in the next cycle, outBusy never high.
- Non-power-of-2: NUM_LANES=5, inLen=7 -> outSel 0,1,2,3,4,0,1.
- Ignored start: inStart pulsed during RUN with inLen=9 -> the frame still ends after the original length; a new frame only starts after DONE.
